// File: rtl/img_buffer.sv
// Byte-stream image assembler: packs NUM_BYTES pixel bytes MSB-first into img_out.
// Optional sticky drop flag on the `overflow` port when IMG_BUF_OVF_EN is defined.
module img_buffer #(
  parameter int IMG_BITS  = 904,
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = IMG_BITS / BYTE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   rx_byte,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                buffer_clear,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
  output logic [6:0]          byte_count
`ifdef IMG_BUF_OVF_EN
  ,
  output logic                overflow
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam int IDX_W = $clog2(IMG_BITS);
  localparam logic [6:0] LAST_IDX = 7'(NUM_BYTES - 1);

  generate
    if ((IMG_BITS % BYTE_W) != 0) begin : g_bad_width
      $error("img_buffer: IMG_BITS must be a multiple of BYTE_W");
    end
  endgenerate

  logic [1:0]       state;
  logic [IDX_W-1:0] slot_lsb;
  logic             accept;

  // Byte k lands in the slice whose LSB is (NUM_BYTES-1-k)*BYTE_W, so byte 0 is topmost.
  always_comb begin
    slot_lsb = IDX_W'((NUM_BYTES - 1 - int'(byte_count)) * BYTE_W);
    accept   = rx_valid && !buffer_clear && (state != S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      byte_count <= '0;
      img_out    <= '0;
    end else if (buffer_clear) begin
      state      <= S_EMPTY;
      byte_count <= '0;
      img_out    <= '0;
    end else if (accept) begin
      img_out[slot_lsb +: BYTE_W] <= rx_byte;
      byte_count                  <= byte_count + 7'd1;
      state                       <= (byte_count == LAST_IDX) ? S_FULL : S_FILL;
    end
  end

`ifdef IMG_BUF_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (buffer_clear) begin
      overflow <= 1'b0;
    end else if (rx_valid && (state == S_FULL)) begin
      overflow <= 1'b1;
    end
  end
`endif

  assign img_buffer_full = (state == S_FULL);
  assign rx_ready        = (state != S_FULL);

endmodule

// File: tb/tb_img_buffer.sv
// Directed bench for img_buffer: fill, overflow drop, clear, clear/last-byte race, async reset.
// Overflow checks are compiled in only when IMG_BUF_OVF_EN is defined.
module tb_img_buffer;

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_ready;
  logic         buffer_clear;
  logic [903:0] img_out;
  logic         img_buffer_full;
  logic [6:0]   byte_count;
`ifdef IMG_BUF_OVF_EN
  logic         overflow;
`endif

  int unsigned  checks;
  int unsigned  errors;
  logic [903:0] exp_img;
  logic [903:0] saved_img;

  img_buffer #(.IMG_BITS(904), .BYTE_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_byte         (rx_byte),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .buffer_clear    (buffer_clear),
    .img_out         (img_out),
    .img_buffer_full (img_buffer_full),
    .byte_count      (byte_count)
`ifdef IMG_BUF_OVF_EN
    ,
    .overflow        (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [903:0] obs, input logic [903:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    buffer_clear = 1'b1;
    @(negedge clk);
    buffer_clear = 1'b0;
  endtask

  task automatic put(input int k, input logic [7:0] b);
    exp_img[903 - 8*k -: 8] = b;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 904'(byte_count), 904'(0));
    check({tag, "_img"},   img_out, '0);
    check({tag, "_full"},  904'(img_buffer_full), 904'(0));
    check({tag, "_ready"}, 904'(rx_ready), 904'(1));
`ifdef IMG_BUF_OVF_EN
    check({tag, "_ovf"},   904'(overflow), 904'(0));
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rx_byte = 8'h00;
    rx_valid = 1'b0;
    buffer_clear = 1'b0;
    exp_img = '0;

    // Reset state
    @(negedge clk);
    check_empty("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0x00..0x70
    for (int i = 0; i < 112; i++) begin
      send(8'(i));
      put(i, 8'(i));
    end
    check("ramp_count112", 904'(byte_count), 904'(112));
    check("ramp_notfull", 904'(img_buffer_full), 904'(0));
    send(8'h70);
    put(112, 8'h70);
    check("ramp_full", 904'(img_buffer_full), 904'(1));
    check("ramp_top", 904'(img_out[903:896]), 904'(8'h00));
    check("ramp_bot", 904'(img_out[7:0]), 904'(8'h70));
    check("ramp_mid", 904'(img_out[903-8*57 -: 8]), 904'(8'h39));
    check("ramp_img", img_out, exp_img);
    check("ramp_count", 904'(byte_count), 904'(113));
    check("ramp_ready", 904'(rx_ready), 904'(0));
`ifdef IMG_BUF_OVF_EN
    check("ramp_ovf0", 904'(overflow), 904'(0));
`endif

    // Extra bytes while full are dropped
    saved_img = exp_img;
    send(8'hFF);
    send(8'hFF);
    send(8'hFF);
    check("drop_img", img_out, saved_img);
    check("drop_count", 904'(byte_count), 904'(113));
    check("drop_full", 904'(img_buffer_full), 904'(1));
`ifdef IMG_BUF_OVF_EN
    check("drop_ovf", 904'(overflow), 904'(1));
`endif
    clear_pulse();
    check_empty("clr_full");

    // Partial fill then clear
    exp_img = '0;
    for (int i = 0; i < 50; i++) begin
      send(8'(i + 1));
      put(i, 8'(i + 1));
    end
    check("part_count", 904'(byte_count), 904'(50));
    check("part_img", img_out, exp_img);
    check("part_ready", 904'(rx_ready), 904'(1));
    clear_pulse();
    check_empty("clr_part");

    // Full image of 0xA5
    for (int i = 0; i < 113; i++) send(8'hA5);
    check("a5_full", 904'(img_buffer_full), 904'(1));
    check("a5_img", img_out, {113{8'hA5}});
    clear_pulse();
    check_empty("clr_a5");

    // Last byte strobed with clear: clear wins
    for (int i = 0; i < 112; i++) send(8'h11);
    buffer_clear = 1'b1;
    send(8'h99);
    buffer_clear = 1'b0;
    check_empty("race");
    @(negedge clk);
    check("race_full_later", 904'(img_buffer_full), 904'(0));

    // Async reset mid-fill
    for (int i = 0; i < 80; i++) send(8'h22);
    check("pre_rst_count", 904'(byte_count), 904'(80));
    #2 rst_n = 1'b0;
    #1 check_empty("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x3C with idle gaps
    for (int i = 0; i < 113; i++) begin
      send(8'h3C);
      if ((i % 7) == 3) repeat (2) @(negedge clk);
    end
    check("gap_full", 904'(img_buffer_full), 904'(1));
    check("gap_img", img_out, {113{8'h3C}});
    check("gap_count", 904'(byte_count), 904'(113));

    // Clear out of FULL after an overflow
    send(8'h01);
    check("gap_hold", img_out, {113{8'h3C}});
`ifdef IMG_BUF_OVF_EN
    check("gap_ovf", 904'(overflow), 904'(1));
`endif
    clear_pulse();
    check_empty("clr_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
